// File: rtl/mux_n_1_scan.sv
// rtl/mux_n_1_scan.sv - registered N:1 word mux with manual select and masked auto-scan
// ptr/cnt are the only scan state; mode is decoded from live en/mode every edge.
module mux_n_1_scan #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = 4,
    parameter int HOLD     = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] a,
    input  logic [SEL_W-1:0]          s,
    input  logic                      en,
    input  logic                      mode,
    input  logic [CHANNELS-1:0]       mask,
    output logic [WIDTH-1:0]          o,
    output logic [SEL_W-1:0]          o_sel,
    output logic                      o_valid,
    output logic                      wrap,
    output logic                      err
);

    localparam int CNT_W = 8;

    logic [WIDTH-1:0] o_q, o_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [SEL_W-1:0] lowest;
    logic [SEL_W-1:0] above;
    logic             above_found;
    logic             ptr_en;
    logic [SEL_W-1:0] next_ptr;
    logic             next_wraps;

    function automatic logic [WIDTH-1:0] word_at(input logic [SEL_W-1:0] idx);
        logic [WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (SEL_W'(i) == idx) w = a[i*WIDTH +: WIDTH];
        end
        return w;
    endfunction

    // Descending scans leave the lowest qualifying index in the result.
    always_comb begin
        lowest      = '0;
        above       = '0;
        above_found = 1'b0;
        ptr_en      = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest = SEL_W'(i);
                if (i > int'(ptr_q)) begin
                    above       = SEL_W'(i);
                    above_found = 1'b1;
                end
                if (SEL_W'(i) == ptr_q) ptr_en = 1'b1;
            end
        end
        next_ptr   = above_found ? above : lowest;
        next_wraps = !above_found;
    end

    always_comb begin
        o_d     = o_q;
        sel_d   = sel_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        ptr_d   = lowest;
        cnt_d   = '0;
        if (en && !mode) begin
            sel_d = s;
            if (int'(s) < CHANNELS) begin
                o_d     = word_at(s);
                valid_d = 1'b1;
            end else begin
                o_d   = '0;
                err_d = 1'b1;
            end
        end else if (en && mode) begin
            o_d   = word_at(ptr_q);
            sel_d = ptr_q;
            ptr_d = ptr_q;
            cnt_d = cnt_q;
            if (mask != '0) begin
                valid_d = ptr_en;
                // A channel dropped from the mask mid-hold is skipped at once.
                if (!ptr_en || cnt_q == CNT_W'(HOLD - 1)) begin
                    ptr_d  = next_ptr;
                    cnt_d  = '0;
                    wrap_d = next_wraps;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q     <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            o_q     <= o_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o       = o_q;
    assign o_sel   = sel_q;
    assign o_valid = valid_q;
    assign wrap    = wrap_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mux_n_1_scan.sv
// tb/tb_mux_n_1_scan.sv - directed and randomized bench for mux_n_1_scan against a behavioural model
module tb_mux_n_1_scan;
    localparam int W  = 16;
    localparam int CH = 12;
    localparam int SW = 4;
    localparam int H  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CH*W-1:0]   a;
    logic [SW-1:0]     s;
    logic              en, mode;
    logic [CH-1:0]     mask;
    logic [W-1:0]      o;
    logic [SW-1:0]     o_sel;
    logic              o_valid, wrap, err;

    logic [W-1:0]      words [CH];
    int                m_ptr, m_cnt;
    logic [W-1:0]      e_o;
    logic [SW-1:0]     e_sel;
    logic              e_valid, e_wrap, e_err;
    int                n_tests = 0;
    int                n_fail  = 0;
    logic [W-1:0]      sparse_exp [12] = '{1, 1, 1, 3, 3, 3, 1, 1, 1, 3, 3, 3};

    mux_n_1_scan #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .HOLD(H)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .s(s), .en(en), .mode(mode), .mask(mask),
        .o(o), .o_sel(o_sel), .o_valid(o_valid), .wrap(wrap), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_cnt = 0;
        e_o = '0; e_sel = '0; e_valid = 0; e_wrap = 0; e_err = 0;
    endtask

    function automatic int first_enabled();
        int r = 0;
        for (int i = CH - 1; i >= 0; i--) if (mask[i]) r = i;
        return r;
    endfunction

    task automatic model_advance();
        int  nxt = m_ptr;
        bit  found = 0;
        for (int k = 1; k <= CH; k++) begin
            if (!found && mask[(m_ptr + k) % CH]) begin
                nxt = (m_ptr + k) % CH;
                found = 1;
            end
        end
        e_wrap = (nxt <= m_ptr);
        m_ptr  = nxt;
        m_cnt  = 0;
    endtask

    task automatic model_edge();
        e_wrap = 0; e_err = 0; e_valid = 0;
        if (!en) begin
            m_ptr = first_enabled(); m_cnt = 0;
        end else if (!mode) begin
            e_sel = s;
            if (s < CH) begin
                e_o = words[s]; e_valid = 1;
            end else begin
                e_o = '0; e_err = 1;
            end
            m_ptr = first_enabled(); m_cnt = 0;
        end else begin
            e_o   = words[m_ptr];
            e_sel = SW'(m_ptr);
            if (mask != '0) begin
                e_valid = mask[m_ptr];
                if (mask[m_ptr] && m_cnt < H - 1) m_cnt++;
                else model_advance();
            end
        end
    endtask

    task automatic step();
        for (int i = 0; i < CH; i++) a[i*W +: W] = words[i];
        model_edge();
        @(posedge clk);
        #1;
        check("o", o, e_o);
        check("o_sel", o_sel, e_sel);
        check("o_valid", o_valid, e_valid);
        check("wrap", wrap, e_wrap);
        check("err", err, e_err);
        check("err_wrap_excl", err & wrap, 0);
    endtask

    task automatic async_reset();
        #1 rst_n = 0;
        #1;
        check("rst_o", o, 0);
        check("rst_o_sel", o_sel, 0);
        check("rst_o_valid", o_valid, 0);
        check("rst_wrap", wrap, 0);
        check("rst_err", err, 0);
        model_reset();
        #1 rst_n = 1;
    endtask

    initial begin
        rst_n = 0; en = 0; mode = 0; s = '0; mask = '0;
        for (int i = 0; i < CH; i++) words[i] = '0;
        a = '0;
        model_reset();
        #12;
        check("init_o", o, 0);
        check("init_o_valid", o_valid, 0);
        check("init_wrap", wrap, 0);
        check("init_err", err, 0);
        rst_n = 1;

        for (int i = 0; i < CH; i++) words[i] = W'(i + 1);
        words[CH-1] = '0;
        en = 1; mode = 0;
        for (int i = 0; i < CH; i++) begin
            s = SW'(i);
            step();
        end
        s = 4'd13; step();
        check("oor_err", err, 1);
        s = 4'd11; step();
        check("in_range_o", o, 0);

        mask = 12'h005; en = 0; step();
        en = 1; mode = 1;
        for (int i = 0; i < 12; i++) begin
            step();
            check("sparse_o", o, sparse_exp[i]);
        end

        mask = 12'hFFF; en = 0; step();
        en = 1;
        for (int i = 0; i < 7; i++) step();
        mask = 12'hFFB; step();
        check("drop_valid", o_valid, 0);
        mask = '0;
        for (int i = 0; i < 3; i++) step();
        mask = 12'hFFB;
        for (int i = 0; i < 8; i++) step();

        async_reset();
        mask = 12'h010; en = 0; step();
        en = 1; mode = 1;
        step();
        check("ch4_first", o, 16'd5);
        for (int i = 0; i < 8; i++) step();
        mode = 0; s = 4'd7; step();
        check("manual_after_scan", o, 16'd8);

        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < CH; i++) words[i] = W'($urandom);
            en   = ($urandom_range(0, 9) != 0);
            mode = ($urandom_range(0, 3) != 0);
            s    = SW'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 5))
                    0: mask = '0;
                    1: mask = CH'(1) << $urandom_range(0, CH - 1);
                    default: mask = CH'($urandom);
                endcase
            end
            step();
            if ($urandom_range(0, 199) == 0) async_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_n_1_scan.md
Name: mux_n_1_scan

Overview:
Parametrised, registered N:1 word multiplexer. It generalises the fixed 16-input, 16-bit mux to CHANNELS inputs of WIDTH bits. It adds two modes: manual select, and an auto-scan sequencer that steps through the enabled channels, holding each for HOLD cycles. It is used wherever a datapath samples several word sources in turn, for example debug readout or a shared bus front-end.

Parameters:
WIDTH, 16, bits per channel word
CHANNELS, 16, number of input channels (2..256)
SEL_W, 4, select/pointer width; must be >= clog2(CHANNELS)
HOLD, 1, cycles each channel is held in scan mode (1..255)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
a  in  CHANNELS*WIDTH  flattened inputs; channel i = a[i*WIDTH +: WIDTH]
s  in  SEL_W  manual channel select
en  in  1  enable; 0 freezes o and deasserts o_valid
mode  in  1  0 = manual, 1 = scan
mask  in  CHANNELS  scan enable per channel (bit i = channel i)
o  out  WIDTH  registered selected word
o_sel  out  SEL_W  channel index that produced o
o_valid  out  1  o holds a valid sample
wrap  out  1  one-cycle pulse when the scan pointer wraps
err  out  1  one-cycle pulse when the manual select is out of range

Behaviour:
- Reset (async, rst_n=0): o=0, o_sel=0, o_valid=0, wrap=0, err=0; internal ptr=0, cnt=0.
- All outputs are registered; latency is 1 cycle from the sampled inputs to o, in both modes.
- Modes are decoded from the live en/mode inputs at each rising edge. There is no separate state register beyond ptr and cnt.
- IDLE (en=0):
  - o and o_sel hold; o_valid<=0; wrap<=0; err<=0.
  - ptr<=lowest set bit of mask (0 if mask==0); cnt<=0.
- MANUAL (en=1, mode=0):
  - s<CHANNELS: o<=a[s], o_sel<=s, o_valid<=1, err<=0. mask is ignored.
  - s>=CHANNELS: o<=0, o_sel<=s, o_valid<=0, err<=1.
  - ptr and cnt preload exactly as in IDLE.
- SCAN (en=1, mode=1):
  - Each edge: o<=a[ptr], o_sel<=ptr, o_valid<=mask[ptr].
  - Normal step: if cnt==HOLD-1, ptr<=next set mask bit strictly after ptr (circular) and cnt<=0; otherwise cnt<=cnt+1.
  - wrap<=1 on the edge where ptr advances to an index <= its current value. This includes the single-enabled-channel case, which wraps on every advance.
  - If mask[ptr]==0 because mask changed mid-hold: o_valid<=0, ptr advances immediately to the next set bit, cnt<=0.
  - mask==0: o<=a[ptr], o_valid<=0, ptr and cnt hold, wrap<=0.
- Entering SCAN: ptr was preloaded while not scanning, so the first valid scan output is the lowest enabled channel, visible after the first scan edge. Each channel then appears on o for exactly HOLD consecutive cycles.
- Leaving SCAN for MANUAL: manual select takes effect on the next edge; the scan position is discarded.
- Mid-operation reset: all state returns to the reset values immediately; scan restarts from the lowest enabled channel.
- err and wrap are never asserted together. err is 0 in scan; wrap is 0 in manual and idle.

Test Plan:
- Manual sweep: WIDTH=16, CHANNELS=16, a[i]=i+1 (a[15]=0), en=1, mode=0, s=0..15 one per cycle -> o = 1,2,...,15,0, one cycle after each s; o_valid=1; o_sel tracks s; err=0.
- Scan, full mask: mask=16'hFFFF, HOLD=1, en=1, mode=1 -> o = 1,2,...,15,0,1,...; wrap pulses exactly on the cycle where o_sel goes 15->0.
- Scan, sparse mask: mask=16'h0005, HOLD=3 -> o = 1,1,1,3,3,3,1,...; wrap pulses on each 2->0 step; o_valid stays 1.
- Out of range: CHANNELS=12, SEL_W=4, mode=0, s=13 -> o=0, o_valid=0, err=1 for one cycle; then s=11 -> o=a[11], err=0.
- Mask edge cases: during scan with HOLD=4 on channel 2, clear mask bit 2 -> next cycle o_valid=0 and ptr moves to the next set bit. Then mask=0 -> o_valid stays 0, ptr holds. Restore mask -> scan resumes.
- Reset/mode change: assert rst_n=0 mid-scan -> o=0, o_valid=0 immediately, asynchronously. After release, mode=1 with mask=16'h0010 -> first o=a[4], wrap on every advance. Switch to mode=0, s=7 -> o=a[7] one cycle later.
